sram_access_ctrl: RTL and testbench

SRAM_ACCESS_CTRL -- requirements
Module: sram_access_ctrl

---
 rtl/sram_access_ctrl.sv | 92 +++++++++
 tb/tb_sram_access_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: two-requester round-robin controller sequencing precharge,
// wordline, write-drive and sense strobes for a 32-word SRAM macro.
module sram_access_ctrl #(
  parameter int DATA_W    = 8,
  parameter int WL_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_we,
  input  logic [4:0]        req_addr0,
  input  logic [4:0]        req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        req_ready,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [4:0]        dec_a,
  output logic              dec_enbl,
  output logic              pchg,
  output logic              wr_drv,
  output logic [DATA_W-1:0] wdata_out,
  output logic              sae,
  input  logic [DATA_W-1:0] sram_rdata
);
  typedef enum logic [1:0] {IDLE, PCHG, WL, DONE} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic last, gnt, accept, we_q, id_q;
  logic [4:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  always_comb begin
    gnt = &req_valid ? ~last : req_valid[1];
    accept = state == IDLE && |req_valid;
    req_ready = (accept && rst_n) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: state_n = accept ? PCHG : IDLE;
      PCHG: begin
        state_n = WL;
        cnt_n = 4'(WL_CYCLES - 1);
      end
      WL: begin
        state_n = cnt == 4'd0 ? DONE : WL;
        cnt_n = cnt == 4'd0 ? cnt : cnt - 4'd1;
      end
      default: state_n = IDLE;
    endcase
  end
  // Strobes are registered from the next state so they toggle cleanly on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      last <= 1'b1;
      we_q <= 1'b0;
      id_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      pchg <= 1'b0;
      dec_enbl <= 1'b0;
      wr_drv <= 1'b0;
      sae <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id <= 1'b0;
      rsp_rdata <= '0;
      dec_a <= '0;
      wdata_out <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      pchg <= state_n == PCHG;
      dec_enbl <= state_n == WL;
      wr_drv <= state_n == WL && we_q;
      sae <= state_n == WL && !we_q && cnt_n == 4'd0;
      rsp_valid <= state_n == DONE;
      if (accept) begin
        last <= gnt;
        id_q <= gnt;
        we_q <= req_we[gnt];
        addr_q <= gnt ? req_addr1 : req_addr0;
        wdata_q <= gnt ? req_wdata1 : req_wdata0;
      end
      if (state_n == WL) dec_a <= addr_q;
      if (state_n == WL && we_q) wdata_out <= wdata_q;
      if (state_n == DONE) rsp_id <= id_q;
      if (sae) rsp_rdata <= sram_rdata;
    end
  end
endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb_sram_access_ctrl: three controllers (WL=2,1,15) on shared random traffic,
// checked every cycle against a transaction-timeline reference model.
module tb_sram_access_ctrl;
  localparam int N = 3;
  function automatic int wl_of(int k);
    return k == 0 ? 2 : k == 1 ? 1 : 15;
  endfunction
  function automatic logic pick(logic [1:0] v, logic l);
    return (v == 2'b11) ? ~l : v[1];
  endfunction
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req_valid = '0, req_we = '0;
  logic [4:0] req_addr0 = '0, req_addr1 = '0;
  logic [7:0] req_wdata0 = '0, req_wdata1 = '0;
  logic [1:0] req_ready [N];
  logic rsp_valid [N], rsp_id [N], dec_enbl [N], pchg [N], wr_drv [N], sae [N];
  logic [7:0] rsp_rdata [N], wdata_out [N], sram_rdata [N];
  logic [4:0] dec_a [N];
  logic [7:0] smem [N][32];
  int c [N];
  logic mwe [N], mid [N], mlast [N], mrdk [N], mg;
  logic [4:0] maddr [N];
  logic [7:0] mwd [N], mrd [N];
  logic [7:0] rm [N][32];
  logic known [N][32];
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : lane
    sram_access_ctrl #(.DATA_W(8), .WL_CYCLES(wl_of(g))) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
      .req_addr0(req_addr0), .req_addr1(req_addr1),
      .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
      .req_ready(req_ready[g]), .rsp_valid(rsp_valid[g]), .rsp_id(rsp_id[g]),
      .rsp_rdata(rsp_rdata[g]), .dec_a(dec_a[g]), .dec_enbl(dec_enbl[g]),
      .pchg(pchg[g]), .wr_drv(wr_drv[g]), .wdata_out(wdata_out[g]),
      .sae(sae[g]), .sram_rdata(sram_rdata[g]));
  end
  always_comb for (int k = 0; k < N; k++) sram_rdata[k] = smem[k][dec_a[k]];
  always @(posedge clk) for (int k = 0; k < N; k++) if (wr_drv[k]) smem[k][dec_a[k]] <= wdata_out[k];
  task automatic ck(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, exp, $time);
  endtask
  // Reference: each lane is idle (c=0) or c cycles past its acceptance edge.
  always @(posedge clk or negedge rst_n)
    for (int k = 0; k < N; k++) begin
      if (!rst_n) begin
        if (c[k] != 0 && mwe[k]) known[k][maddr[k]] = 1'b0;
        c[k] = 0; mlast[k] = 1'b1; mrd[k] = '0; mrdk[k] = 1'b1;
      end else if (c[k] == 0) begin
        if (|req_valid) begin
          mg = pick(req_valid, mlast[k]);
          mlast[k] = mg; mid[k] = mg; mwe[k] = req_we[mg];
          maddr[k] = mg ? req_addr1 : req_addr0;
          mwd[k] = mg ? req_wdata1 : req_wdata0;
          c[k] = 1;
          if (mwe[k]) begin rm[k][maddr[k]] = mwd[k]; known[k][maddr[k]] = 1'b1; end
        end
      end else begin
        if (c[k] == 1 + wl_of(k) && !mwe[k]) begin mrd[k] = rm[k][maddr[k]]; mrdk[k] = known[k][maddr[k]]; end
        c[k] = (c[k] == 2 + wl_of(k)) ? 0 : c[k] + 1;
      end
    end
  always @(negedge clk)
    for (int k = 0; k < N; k++) begin
      int cc, wl;
      logic en;
      logic [1:0] er;
      cc = c[k]; wl = wl_of(k);
      en = cc >= 2 && cc <= 1 + wl;
      er = (rst_n && cc == 0 && |req_valid) ? (pick(req_valid, mlast[k]) ? 2'b10 : 2'b01) : 2'b00;
      ck($sformatf("l%0d_ready", k), req_ready[k], er);
      ck($sformatf("l%0d_pchg", k), pchg[k], cc == 1);
      ck($sformatf("l%0d_dec_enbl", k), dec_enbl[k], en);
      ck($sformatf("l%0d_wr_drv", k), wr_drv[k], en && mwe[k]);
      ck($sformatf("l%0d_sae", k), sae[k], cc == 1 + wl && !mwe[k]);
      ck($sformatf("l%0d_rsp_valid", k), rsp_valid[k], cc == 2 + wl);
      ck($sformatf("l%0d_excl", k), {pchg[k] & (dec_enbl[k] | wr_drv[k] | sae[k]), wr_drv[k] & sae[k]}, 0);
      ck($sformatf("l%0d_onehot", k), $countones(req_ready[k]) <= 1, 1);
      if (en) ck($sformatf("l%0d_dec_a", k), dec_a[k], maddr[k]);
      if (en && mwe[k]) ck($sformatf("l%0d_wdata_out", k), wdata_out[k], mwd[k]);
      if (cc == 2 + wl) ck($sformatf("l%0d_rsp_id", k), rsp_id[k], mid[k]);
      if (mrdk[k]) ck($sformatf("l%0d_rsp_rdata", k), rsp_rdata[k], mrd[k]);
    end
  task automatic drive(input logic [1:0] v, we, input logic [4:0] a0, a1, input logic [7:0] d0, d1);
    req_valid = v; req_we = we; req_addr0 = a0; req_addr1 = a1; req_wdata0 = d0; req_wdata1 = d1;
  endtask
  task automatic wait_idle();
    int i = 0;
    while ((c[0] | c[1] | c[2]) != 0 && i < 300) begin @(posedge clk); #1; i++; end
    ck("idle_timeout", (c[0] | c[1] | c[2]) != 0, 0);
  endtask
  task automatic issue(input logic [1:0] v, we, input logic [4:0] a0, a1, input logic [7:0] d0, d1);
    @(posedge clk); #1 drive(v, we, a0, a1, d0, d1);
    @(posedge clk); #1 req_valid = 2'b00;
    wait_idle();
  endtask
  task automatic reset_pulse();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  initial begin
    int ids [$];
    int i;
    for (int k = 0; k < N; k++)
      for (int a = 0; a < 32; a++) begin smem[k][a] = '0; rm[k][a] = '0; known[k][a] = 1'b1; end
    for (int k = 0; k < N; k++) begin c[k] = 0; mlast[k] = 1'b1; mrd[k] = '0; mrdk[k] = 1'b1; mwe[k] = 1'b0; end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    issue(2'b01, 2'b01, 5'd5, 5'd0, 8'hA5, 8'h00);
    issue(2'b01, 2'b00, 5'd5, 5'd0, 8'h00, 8'h00);
    for (int k = 0; k < N; k++) ck($sformatf("l%0d_rd_a5", k), rsp_rdata[k], 8'hA5);
    issue(2'b01, 2'b01, 5'd0, 5'd0, 8'h11, 8'h00);
    issue(2'b10, 2'b10, 5'd0, 5'd31, 8'h00, 8'hEE);
    issue(2'b01, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
    for (int k = 0; k < N; k++) ck($sformatf("l%0d_rd_a0", k), rsp_rdata[k], 8'h11);
    issue(2'b10, 2'b00, 5'd0, 5'd31, 8'h00, 8'h00);
    for (int k = 0; k < N; k++) ck($sformatf("l%0d_rd_a31", k), rsp_rdata[k], 8'hEE);
    reset_pulse();
    drive(2'b11, 2'b00, 5'd3, 5'd4, 8'h00, 8'h00);
    i = 0;
    while (ids.size() < 4 && i < 200) begin @(negedge clk); if (rsp_valid[0]) ids.push_back(int'(rsp_id[0])); i++; end
    ck("rr_timeout", ids.size(), 4);
    for (int j = 0; j < ids.size(); j++) ck($sformatf("rr_id%0d", j), ids[j], j % 2);
    @(posedge clk); #1 req_valid = 2'b00;
    wait_idle();
    @(posedge clk); #1 drive(2'b01, 2'b01, 5'd9, 5'd0, 8'h5A, 8'h00);
    @(posedge clk); #1 req_valid = 2'b00;
    @(posedge clk); #1;
    ck("pre_rst_dec_enbl", dec_enbl[0], 1);
    rst_n = 1'b0;
    drive(2'b10, 2'b00, 5'd0, 5'd7, 8'h00, 8'h00);
    #1;
    ck("rst_dec_enbl", dec_enbl[0], 0);
    ck("rst_wr_drv", wr_drv[0], 0);
    ck("rst_ready", req_ready[0], 2'b00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    ck("rel_ready", req_ready[0], 2'b10);
    @(posedge clk); #1 req_valid = 2'b00;
    wait_idle();
    repeat (10000) begin
      @(posedge clk); #1;
      drive(2'($urandom), 2'($urandom), 5'($urandom), 5'($urandom), 8'($urandom), 8'($urandom));
    end
    @(posedge clk); #1 req_valid = 2'b00;
    wait_idle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
